// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
//   Merges N valid/ready upstream streams into one registered downstream stream.
//   The grant is found by a combinational round-robin search over up_valid_in.
//   The search starts at ptr and wraps from N-1 to 0. After each accepted word,
//   ptr moves to the requester just past the grant.
//   The output stage is a one-entry register. It accepts a new word in the same
//   cycle the held word drains, so it can pass one word per cycle.
//
// Configuration:
//   ARB_FIXED_PRIO_EN  When defined, the search always starts at index 0, so the
//                      lowest index wins, and there is no ptr register.
//                      When undefined (the default), arbitration is round-robin.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   data_in       N*WIDTH; requester k data at [k*WIDTH +: WIDTH]
//   up_valid_in   N; per-requester valid
//   up_ready_out  N; per-requester ready, only the granted bit can be set
//   data_out      WIDTH; registered merged data
//   dn_valid_out  registered downstream valid
//   dn_ready_in   downstream ready
//   grant_id_out  $clog2(N); index of the requester whose word is in data_out
module handshake_rr_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   data_in,
  input  logic [N-1:0]         up_valid_in,
  output logic [N-1:0]         up_ready_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 dn_valid_out,
  input  logic                 dn_ready_in,
  output logic [$clog2(N)-1:0] grant_id_out
);

  localparam int unsigned IDW = $clog2(N);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [IDW-1:0]   start_idx;
  logic [IDW-1:0]   grant;
  logic             grant_found;
  logic [2*N-1:0]   valid_dbl;
  logic [N-1:0]     valid_rot;
  logic [IDW:0]     grant_sum;
  logic [WIDTH-1:0] sel_data;
  logic             acc_en;
  logic             up_xfer;
  logic             dn_xfer;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: the search always begins at requester 0.
  assign start_idx = '0;
`else
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;

  assign start_idx = ptr;
  // The next search starts just past the current grant, wrapping at N-1.
  assign ptr_next  = (grant == IDW'(N - 1)) ? '0 : grant + IDW'(1);
`endif

  // Output register can take a word when it is empty or is draining this cycle.
  assign acc_en       = (state == ST_EMPTY) | dn_ready_in;
  assign dn_valid_out = (state == ST_FULL);
  assign dn_xfer      = (state == ST_FULL) & dn_ready_in;

  // Rotated priority search.
  // Bit i of valid_rot is requester (start_idx + i) mod N. The lowest set bit
  // of valid_rot wins, and that offset is mapped back to the real index.
  always_comb begin
    valid_dbl   = {up_valid_in, up_valid_in} >> start_idx;
    valid_rot   = valid_dbl[N-1:0];
    grant_found = |valid_rot;
    grant_sum   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        grant_sum = {1'b0, start_idx} + (IDW+1)'(i);
      end
    end
    if (grant_sum >= (IDW+1)'(N)) begin
      grant_sum = grant_sum - (IDW+1)'(N);
    end
    grant = grant_sum[IDW-1:0];
  end

  // Data mux for the granted requester.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (grant == IDW'(k)) begin
        sel_data = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes to the granted requester only, and is forced low during reset.
  always_comb begin
    up_ready_out = '0;
    for (int k = 0; k < int'(N); k++) begin
      up_ready_out[k] = !rst && grant_found && acc_en && (grant == IDW'(k));
    end
  end

  assign up_xfer = !rst && grant_found && acc_en;

  // Output stage EMPTY/FULL register.
  // An accept has priority over a drain, so drain-and-accept in the same cycle
  // keeps the stage FULL with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_EMPTY;
      data_out     <= '0;
      grant_id_out <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr          <= '0;
`endif
    end else if (up_xfer) begin
      state        <= ST_FULL;
      data_out     <= sel_data;
      grant_id_out <= grant;
`ifndef ARB_FIXED_PRIO_EN
      ptr          <= ptr_next;
`endif
    end else if (dn_xfer) begin
      state        <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench for handshake_rr_arbiter (WIDTH=32, N=4).
// Each requester draws its words from a source table. A reference model of the
// arbiter predicts the grant and the ready vector. Every accepted word is pushed
// to a scoreboard queue, and the queue is popped when the DUT drains a word.
module tb_handshake_rr_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       up_valid_in;
  logic [N-1:0]       up_ready_out;
  logic [WIDTH-1:0]   data_out;
  logic               dn_valid_out;
  logic               dn_ready_in;
  logic [1:0]         grant_id_out;

  handshake_rr_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .up_valid_in  (up_valid_in),
    .up_ready_out (up_ready_out),
    .data_out     (data_out),
    .dn_valid_out (dn_valid_out),
    .dn_ready_in  (dn_ready_in),
    .grant_id_out (grant_id_out)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;

  logic [31:0] src_w [N][DEPTH];
  int          src_idx [N];
  int          src_len [N];
  logic [N-1:0] en_mask;

  logic        m_full;
  int          m_ptr;
  logic [33:0] exp_q [$];
  int          rx_cnt [N];
  logic        order_chk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic int find_grant(input logic [N-1:0] v, input int start);
    int k;
`ifdef ARB_FIXED_PRIO_EN
    start = 0;
`endif
    for (int i = 0; i < int'(N); i++) begin
      k = (start + i) % int'(N);
      if (((v >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction

  function automatic int remaining();
    int r;
    r = 0;
    for (int k = 0; k < int'(N); k++) r += src_len[k] - src_idx[k];
    return r;
  endfunction

  task automatic clear_src();
    for (int k = 0; k < int'(N); k++) begin
      src_idx[k] = 0;
      src_len[k] = 0;
    end
  endtask

  // Present each enabled requester's next source word.
  task automatic drive();
    logic has;
    for (int k = 0; k < int'(N); k++) begin
      has = en_mask[k] && (src_idx[k] < src_len[k]);
      up_valid_in[k] = has;
      data_in[k*WIDTH +: WIDTH] = has ? src_w[k][src_idx[k]] : 32'h0;
    end
  endtask

  // One clock cycle: entered and left on a negative edge.
  task automatic tick();
    int          g;
    logic        acc;
    logic [N-1:0] exp_rdy;
    logic [33:0] e;
    drive();
    #1;
    acc     = !m_full || dn_ready_in;
    g       = find_grant(up_valid_in, m_ptr);
    exp_rdy = (g >= 0 && acc) ? (4'b0001 << g) : 4'b0000;
    chk("up_ready", 64'(up_ready_out), 64'(exp_rdy));
    chk("dn_valid", 64'(dn_valid_out), 64'(m_full));
    if (m_full && dn_ready_in) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 64'(data_out), 64'(e[31:0]));
        chk("sb_gid", 64'(grant_id_out), 64'(e[33:32]));
      end
    end
    if (order_chk && dn_valid_out && dn_ready_in) begin
      chk("rand_order", 64'(data_out), 64'(int'(grant_id_out) * 256 + rx_cnt[grant_id_out]));
      rx_cnt[grant_id_out]++;
    end
    @(posedge clk);
    if (g >= 0 && acc) begin
      exp_q.push_back({2'(g), src_w[g][src_idx[g]]});
      src_idx[g]++;
      m_full = 1'b1;
      m_ptr  = (g + 1) % int'(N);
    end else if (m_full && dn_ready_in) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en_mask = '0;
    repeat (n) tick();
  endtask

  // Assert reset (entered on a negative edge) with all requesters valid, so
  // the ready gating by reset is actually exercised.
  task automatic do_reset(input int cycles);
    rst         = 1'b1;
    en_mask     = '0;
    up_valid_in = '1;
    data_in     = {N{32'hDEAD_BEEF}};
    #1;
    chk("rst_now_valid", 64'(dn_valid_out), 64'd0);
    chk("rst_now_data", 64'(data_out), 64'd0);
    chk("rst_now_gid", 64'(grant_id_out), 64'd0);
    chk("rst_now_ready", 64'(up_ready_out), 64'd0);
    m_full = 1'b0;
    m_ptr  = 0;
    exp_q.delete();
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_valid", 64'(dn_valid_out), 64'd0);
      chk("rst_hold_ready", 64'(up_ready_out), 64'd0);
    end
    up_valid_in = '0;
    rst         = 1'b0;
  endtask

  initial begin
    int cyc;
    rst         = 1'b1;
    up_valid_in = '0;
    data_in     = '0;
    dn_ready_in = 1'b0;
    en_mask     = '0;
    order_chk   = 1'b0;
    m_full      = 1'b0;
    m_ptr       = 0;
    for (int k = 0; k < int'(N); k++) rx_cnt[k] = 0;
    clear_src();
    @(negedge clk);

    // Post-reset single source: requester 2 sends 0xA5.
    do_reset(10);
    clear_src();
    src_len[2] = 1; src_w[2][0] = 32'hA5;
    en_mask = 4'b0100; dn_ready_in = 1'b1;
    tick();
    chk("single_valid", 64'(dn_valid_out), 64'd1);
    chk("single_data", 64'(data_out), 64'hA5);
    chk("single_gid", 64'(grant_id_out), 64'd2);

`ifndef ARB_FIXED_PRIO_EN
    // Wrap-around: ptr is 3, requesters 0 and 3 valid -> 3, then 0, then ptr=1.
    clear_src();
    src_len[0] = 1; src_w[0][0] = 32'h0A;
    src_len[3] = 1; src_w[3][0] = 32'h3A;
    en_mask = 4'b1001;
    tick();
    chk("wrap1_data", 64'(data_out), 64'h3A);
    chk("wrap1_gid", 64'(grant_id_out), 64'd3);
    tick();
    chk("wrap2_data", 64'(data_out), 64'h0A);
    chk("wrap2_gid", 64'(grant_id_out), 64'd0);
    clear_src();
    src_len[0] = 1; src_w[0][0] = 32'h0B;
    src_len[1] = 1; src_w[1][0] = 32'h1B;
    en_mask = 4'b0011;
    tick();
    chk("wrap3_data", 64'(data_out), 64'h1B);
    chk("wrap3_gid", 64'(grant_id_out), 64'd1);
`endif
    idle(3);

    // All-valid rotation: requester k sends k*16+i.
    do_reset(2);
    clear_src();
    for (int k = 0; k < int'(N); k++) begin
      src_len[k] = 4;
      for (int i = 0; i < 4; i++) src_w[k][i] = 32'(k * 16 + i);
    end
    en_mask = 4'b1111; dn_ready_in = 1'b1;
    for (int n = 0; n < 16; n++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      chk("rot_data", 64'(data_out), 64'((n / 4) * 16 + n % 4));
      chk("rot_gid", 64'(grant_id_out), 64'(n / 4));
`else
      chk("rot_data", 64'(data_out), 64'((n % 4) * 16 + n / 4));
      chk("rot_gid", 64'(grant_id_out), 64'(n % 4));
`endif
    end
    idle(2);

    // Back-pressure: requesters 1 and 3 valid, downstream stalled 4 cycles.
    do_reset(2);
    clear_src();
    src_len[1] = 2; src_w[1][0] = 32'h111; src_w[1][1] = 32'h112;
    src_len[3] = 2; src_w[3][0] = 32'h333; src_w[3][1] = 32'h334;
    en_mask = 4'b1010; dn_ready_in = 1'b0;
    tick();
    chk("bp_first", 64'(data_out), 64'h111);
    repeat (3) begin
      tick();
      chk("bp_hold_data", 64'(data_out), 64'h111);
      chk("bp_hold_valid", 64'(dn_valid_out), 64'd1);
      chk("bp_ready", 64'(up_ready_out), 64'd0);
    end
    dn_ready_in = 1'b1;
    tick();
`ifdef ARB_FIXED_PRIO_EN
    chk("bp_next_data", 64'(data_out), 64'h112);
`else
    chk("bp_next_data", 64'(data_out), 64'h333);
    chk("bp_next_gid", 64'(grant_id_out), 64'd3);
`endif
    chk("bp_next_valid", 64'(dn_valid_out), 64'd1);
    tick();
`ifndef ARB_FIXED_PRIO_EN
    chk("bp_after_data", 64'(data_out), 64'h112);
`endif
    idle(3);

    // Reset mid-stall: the held 0x1234 must vanish, never drained.
    do_reset(2);
    clear_src();
    src_len[0] = 1; src_w[0][0] = 32'h1234;
    en_mask = 4'b0001; dn_ready_in = 1'b0;
    tick();
    chk("ms_data", 64'(data_out), 64'h1234);
    en_mask = '0;
    tick();
    do_reset(1);
    dn_ready_in = 1'b1;
    idle(3);

    // Random scoreboard run: 64 words per requester, random valid and ready.
    do_reset(2);
    clear_src();
    for (int k = 0; k < int'(N); k++) begin
      src_len[k] = int'(DEPTH);
      rx_cnt[k]  = 0;
      for (int i = 0; i < int'(DEPTH); i++) src_w[k][i] = 32'(k * 256 + i);
    end
    order_chk = 1'b1;
    cyc = 0;
    while (remaining() > 0 && cyc < 4000) begin
      en_mask     = 4'($urandom);
      dn_ready_in = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    en_mask = '0; dn_ready_in = 1'b1;
    while (m_full && cyc < 4100) begin
      tick();
      cyc++;
    end
    chk("rand_left", 64'(remaining()), 64'd0);
    for (int k = 0; k < int'(N); k++) chk("rand_count", 64'(rx_cnt[k]), 64'(DEPTH));
    order_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/handshake_rr_arbiter.md
HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of every stream.
REQ-002 Parameter N, default 4: number of upstream requesters, legal range 2..8.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port data_in, input, N*WIDTH: requester k data at bits [k*WIDTH +: WIDTH].
REQ-006 Port up_valid_in, input, N: per-requester valid.
REQ-007 Port up_ready_out, output, N: per-requester ready.
REQ-008 Port data_out, output, WIDTH: registered merged data.
REQ-009 Port dn_valid_out, output, 1: registered downstream valid.
REQ-010 Port dn_ready_in, input, 1: downstream ready.
REQ-011 Port grant_id_out, output, $clog2(N): index of the requester whose word is in data_out.

Function
REQ-012 Transfer rule: a transfer on any port SHALL occur only in a cycle where that port's valid and ready are both 1.
REQ-013 Output stage: a one-entry register with states EMPTY (dn_valid_out=0) and FULL (dn_valid_out=1).
REQ-014 Accept enable: acc_en = !dn_valid_out | dn_ready_in.
REQ-015 Grant selection:
- Combinational search over up_valid_in.
- Search starts at pointer ptr and wraps from N-1 to 0.
- The first set bit SHALL be the grant g.
REQ-016 Ready drive: up_ready_out[g] SHALL equal acc_en, and every other bit of up_ready_out SHALL be 0.
REQ-017 No requests: if up_valid_in == 0, up_ready_out SHALL be all 0 and ptr SHALL hold.
REQ-018 Ready independence: up_ready_out SHALL never depend on any up_valid_in bit other than through grant selection, and no requester SHALL see ready without being granted.
REQ-019 Upstream transfer, on the following edge:
- data_out <= data_in[g].
- grant_id_out <= g.
- dn_valid_out <= 1.
- ptr <= (g+1) mod N.
REQ-020 Latency: exactly 1 cycle from upstream transfer to dn_valid_out high.
REQ-021 Throughput: 1 word per cycle when dn_ready_in is held 1.
REQ-022 Drain only: a downstream transfer without an upstream transfer SHALL set dn_valid_out to 0.
REQ-023 Simultaneous drain and accept: the register SHALL stay FULL with the new word, and no cycle gap is allowed.
REQ-024 Stall: while FULL and dn_ready_in=0, data_out, grant_id_out and dn_valid_out SHALL hold, and up_ready_out SHALL be all 0.
REQ-025 Fairness: with all N requesters continuously valid and no stall, grants SHALL rotate 0,1,...,N-1,0,...
REQ-026 Word ordering: no word SHALL be dropped or duplicated, and per-requester order SHALL be preserved.

Reset
REQ-027 While rst=1 the block SHALL hold:
- dn_valid_out=0.
- data_out=0.
- grant_id_out=0.
- ptr=0.
- up_ready_out=0.
REQ-028 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-029 Reset mid-operation SHALL discard any held word, with no downstream transfer.
REQ-030 In the first cycle after rst deasserts, up_ready_out[g] SHALL be 1 for the grant g.

Configuration
REQ-031 Macro ARB_FIXED_PRIO_EN selects the arbitration policy.
REQ-032 ARB_FIXED_PRIO_EN defined:
- Search SHALL always start at index 0, so the lowest index wins.
- ptr SHALL be absent or constant 0.
- REQ-025 SHALL be waived.
REQ-033 ARB_FIXED_PRIO_EN undefined: round-robin per REQ-015 and REQ-019.

Verification
REQ-034 Post-reset single source: reset 10 cycles; up_valid_in=4'b0100, data 0xA5, dn_ready_in=1 -> next cycle dn_valid_out=1, data_out=0xA5, grant_id_out=2, ptr=3.
REQ-035 All-valid rotation: requester k sends k*16+i for i=0..3, dn_ready_in=1 -> output order 0x00,0x10,0x20,0x30,0x01,0x11,..., grant_id_out cycling 0,1,2,3; with ARB_FIXED_PRIO_EN -> 0x00,0x01,0x02,0x03, then requester 1.
REQ-036 Back-pressure:
- Stimulus: dn_ready_in=0 for 4 cycles while requesters 1 and 3 are valid.
- Required: exactly one word accepted, data_out stable, up_ready_out=0 during the stall.
- Then raise dn_ready_in: the next word follows back-to-back.
REQ-037 Wrap-around: ptr=3, requesters 0 and 3 valid -> grant 3 first, then 0; ptr goes 3->0->1.
REQ-038 Reset mid-stall: FULL with 0x1234, assert rst for 1 cycle -> dn_valid_out=0 immediately, and 0x1234 is never transferred.
REQ-039 Scoreboard: 64 random words per requester with random valid and random dn_ready_in -> all 256 received, per-requester order intact, no duplicates.
